// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX-stage issue logic and the muldiv_seq sequencer.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in1, in2, flush, wr_hi, wr_lo, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, in1, in2, flush, wr_hi, wr_lo, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add/subtract step per cycle.
// Optional: define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]     mc_q, mc_d;     // mul: shifted multiplicand; div: {raw in1, divisor}
    logic [WIDTH-1:0]  mp_q, mp_d;     // mul: multiplier; div: dividend shifting into quotient
    logic [W2-1:0]     acc_q, acc_d;   // mul: product; div: remainder in low word
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_zero_q, div_zero_d;

    logic              accepting;
    logic              accept;
    logic              signed_op;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [W2-1:0]     mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_ok;
    logic              last_step;
    logic              mul_early;
    logic [W2-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    // Operand conditioning at acceptance: magnitudes plus recorded result signs
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.in1[WIDTH-1];
        b_neg     = signed_op & bus.in2[WIDTH-1];
        a_mag     = a_neg ? WIDTH'(~bus.in1 + WIDTH'(1)) : bus.in1;
        b_mag     = b_neg ? WIDTH'(~bus.in2 + WIDTH'(1)) : bus.in2;
        accepting = (state_q == S_IDLE) || (state_q == S_DONE);
        accept    = accepting & bus.start & ~bus.flush;
    end

    // Per-step datapath and final sign correction
    always_comb begin
        mul_sum   = acc_q + (mp_q[0] ? mc_q : '0);
        div_shift = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mc_q[WIDTH-1:0]};
        div_ok    = ~div_diff[WIDTH];
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        mul_early = ~is_div_q & (mp_q[WIDTH-1:1] == '0);
`else
        mul_early = 1'b0;
`endif
        prod_fix  = neg_lo_q ? W2'(~acc_q + W2'(1)) : acc_q;
        quo_fix   = neg_lo_q ? WIDTH'(~mp_q + WIDTH'(1)) : mp_q;
        rem_fix   = neg_hi_q ? WIDTH'(~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    end

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_d       = mc_q;
        mp_d       = mp_q;
        acc_d      = acc_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        if (!busy_q && bus.wr_hi) hi_d = bus.wdata;
        if (!busy_q && bus.wr_lo) lo_d = bus.wdata;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d    = S_CALC;
                    cnt_d      = '0;
                    is_div_d   = bus.op[1];
                    neg_lo_d   = a_neg ^ b_neg;
                    neg_hi_d   = bus.op[1] ? a_neg : (a_neg ^ b_neg);
                    dz_d       = bus.op[1] & (bus.in2 == '0);
                    mc_d       = bus.op[1] ? {bus.in1, b_mag} : {{WIDTH{1'b0}}, a_mag};
                    mp_d       = bus.op[1] ? a_mag : b_mag;
                    acc_d      = '0;
                    div_zero_d = 1'b0;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = {{WIDTH{1'b0}}, div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]};
                        mp_d  = {mp_q[WIDTH-2:0], div_ok};
                    end else begin
                        acc_d = mul_sum;
                        mc_d  = mc_q << 1;
                        mp_d  = mp_q >> 1;
                    end
                    if (last_step || mul_early) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_DONE;
                    div_zero_d = dz_q;
                    if (!is_div_q) begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = mc_q[W2-1:WIDTH];
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mc_q       <= '0;
            mp_q       <= '0;
            acc_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mc_q       <= mc_d;
            mp_q       <= mp_d;
            acc_q      <= acc_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic, latency, flush, reset and HI/LO writes.
module tb_muldiv_seq;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for exactly one edge; returns in cycle 1 of it
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            tick();
            lat++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done not seen, got cycle %0d need <100", lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", bus.done); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b need 0", bus.div_zero); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h need 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h need 0", bus.lo); end
    endtask

    task automatic test_arith();
        int lat, bn;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bn);
        checks++; if (lat != 34) begin errors++; $display("FAIL multu_lat: got %0d need 34", lat); end
        checks++; if (bn != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d need 33", bn); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_done: got %b need 0", bus.busy); end
        checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h need fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h need 00000001", bus.lo); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b need 0", bus.done); end

        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(lat, bn);
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h need ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h need ffffffeb", bus.lo); end
        tick();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat, bn);
        checks++; if (lat != 34) begin errors++; $display("FAIL div_lat: got %0d need 34", lat); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h need fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h need ffffffff", bus.hi); end
        tick();
    endtask

    task automatic test_div_zero();
        int lat, bn;
        issue(OP_DIVU, 32'h0000_0007, 32'h0);
        wait_done(lat, bn);
        checks++; if (lat != 34) begin errors++; $display("FAIL dz_lat: got %0d need 34", lat); end
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h need ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'h0000_0007) begin errors++; $display("FAIL dz_hi: got %h need 00000007", bus.hi); end
        checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b need 1", bus.div_zero); end
        tick();
        checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky: got %b need 1", bus.div_zero); end
        issue(OP_MULTU, 32'h2, 32'h3);
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b need 0", bus.div_zero); end
        wait_done(lat, bn);
        checks++; if (bus.lo !== 32'h6) begin errors++; $display("FAIL mul23_lo: got %h need 00000006", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL mul23_hi: got %h need 00000000", bus.hi); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bn);
        checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo: got %h need 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL divmin_hi: got %h need 00000000", bus.hi); end
        issue(OP_DIVU, 32'd100, 32'd7);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b need 1", bus.busy); end
        wait_done(lat, bn);
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_lat: got %0d need 34", lat); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL b2b_lo: got %h need 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h need 00000002", bus.hi); end
        tick();
    endtask

    task automatic test_flush_ignore();
        int cyc, dn;
        logic [31:0] mb;
`ifdef MULDIV_EARLY_OUT_EN
        mb = 32'hFFFF_FFFF;
`else
        mb = 32'd5;
`endif
        issue(OP_MULTU, 32'd5, mb);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b need 0", bus.busy); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dn++;
            tick();
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL flush_nodone: got %0d pulses need 0", dn); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL flush_hi: got %h need 00000002", bus.hi); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL flush_lo: got %h need 0000000e", bus.lo); end

        issue(OP_MULTU, 32'd3, 32'hFFFF_FFFF);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                bus.in1 = 32'd7; bus.in2 = 32'd7; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        checks++; if (cyc != 34) begin errors++; $display("FAIL ignore_lat: got %0d need 34", cyc); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL ignore_hi: got %h need 00000002", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL ignore_lo: got %h need fffffffd", bus.lo); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_noqueue: got busy %b need 0", bus.busy); end
    endtask

    task automatic test_hilo_write_reset();
        int dn;
        bus.wr_hi = 1'b1; bus.wdata = 32'h1234_5678;
        tick();
        bus.wr_hi = 1'b0;
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h need 12345678", bus.hi); end
        bus.wr_lo = 1'b1; bus.wdata = 32'hCAFE_F00D;
        tick();
        bus.wr_lo = 1'b0;
        checks++; if (bus.lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo: got %h need cafef00d", bus.lo); end

        issue(OP_MULTU, 32'd3, 32'hFFFF_FFFF);
        repeat (2) tick();
        bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.wr_hi = 1'b0;
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_busy: got %h need 12345678", bus.hi); end
        repeat (16) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h need 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midrst_lo: got %h need 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b need 0", bus.busy); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dn++;
            tick();
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL midrst_nodone: got %0d pulses need 0", dn); end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.flush = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_arith();
        test_div_zero();
        test_back_to_back();
        test_flush_ignore();
        test_hilo_write_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
